// File: rtl/dnn_pkg.sv
// ============================================================================
// Module  : dnn_pkg
// Brief   : Shared classifier definitions (class count, class index type)
//           plus the skid-buffer state encoding of the one-hot decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dnn_pkg;

    // Number of classes produced by the DNN output stage
    localparam int NUM_CLASSES = 10;
    localparam int CLASS_IDX_W = $clog2(NUM_CLASSES);

    // Binary class index shared with the encoder and the result formatter
    typedef logic [CLASS_IDX_W-1:0] class_idx_t;

    // Occupancy of the decoder's output/skid pair
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,  // nothing held, out_valid low
        SKID_ONE   = 2'd1,  // output register full
        SKID_TWO   = 2'd2   // output register and skid register full
    } skid_state_t;

endpackage : dnn_pkg

`default_nettype wire

// File: rtl/one_hot_decode_stream_onehot_to_idx.sv
// ============================================================================
// Module  : onehot_to_idx
// Brief   : Combinational one-hot to binary index converter. The lowest set
//           bit wins; err flags any vector whose popcount is not exactly one.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_to_idx #(
    parameter  int N     = 10,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             err
);

    // Clearing the lowest set bit leaves a non-zero value only if two or
    // more bits were set, which avoids a full popcount tree.
    logic [N-1:0] w_minus_one;
    logic         w_zero;
    logic         w_multi;

    assign w_minus_one = onehot - N'(1);
    assign w_zero      = (onehot == '0);
    assign w_multi     = ((onehot & w_minus_one) != '0);

    // Priority scan from the top so the lowest set bit is the last to assign
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign err = w_zero | w_multi;

endmodule : onehot_to_idx

`default_nettype wire

// File: rtl/one_hot_decode_stream.sv
// ============================================================================
// Module  : one_hot_decode_stream
// Brief   : Streaming one-hot to class-index decoder with valid/ready on both
//           sides, 1-cycle latency, full throughput via a one-entry skid
//           register. Optional per-class statistics counters are built when
//           ONE_HOT_DECODE_STATS_EN is defined; otherwise stat_cnt/err_cnt
//           read as zero and stat_clr/stat_sel are ignored.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module one_hot_decode_stream
    import dnn_pkg::*;
#(
    parameter  int N     = NUM_CLASSES,
    parameter  int CNT_W = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_err,
    input  logic             stat_clr,
    input  logic [IDX_W-1:0] stat_sel,
    output logic [CNT_W-1:0] stat_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // ------------------------------------------------------------------
    // Decode of the incoming vector
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_dec_idx;
    logic             w_dec_err;

    onehot_to_idx #(
        .N (N)
    ) u_onehot_to_idx (
        .onehot (in_onehot),
        .idx    (w_dec_idx),
        .err    (w_dec_err)
    );

    // ------------------------------------------------------------------
    // Output register, skid register and handshake state
    // ------------------------------------------------------------------
    skid_state_t      r_state;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_err;
    logic [IDX_W-1:0] r_skid_idx;
    logic             r_skid_err;
    logic             r_in_ready;

    logic             w_acc;
    logic             w_drain;

    assign w_acc   = in_valid & r_in_ready;
    assign w_drain = r_out_valid & out_ready;

    // Skid FSM: the skid only fills when a new vector arrives while the
    // output is stalled, and in_ready is the registered inverse of that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SKID_EMPTY;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_err   <= 1'b0;
            r_skid_idx  <= '0;
            r_skid_err  <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_acc) begin
                        r_out_idx   <= w_dec_idx;
                        r_out_err   <= w_dec_err;
                        r_out_valid <= 1'b1;
                        r_state     <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (w_acc && w_drain) begin
                        r_out_idx <= w_dec_idx;
                        r_out_err <= w_dec_err;
                    end else if (w_acc) begin
                        r_skid_idx <= w_dec_idx;
                        r_skid_err <= w_dec_err;
                        r_in_ready <= 1'b0;
                        r_state    <= SKID_TWO;
                    end else if (w_drain) begin
                        r_out_valid <= 1'b0;
                        r_state     <= SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    // in_ready is low here, so no accept can coincide
                    if (w_drain) begin
                        r_out_idx  <= r_skid_idx;
                        r_out_err  <= r_skid_err;
                        r_in_ready <= 1'b1;
                        r_state    <= SKID_ONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= SKID_EMPTY;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_err   = r_out_err;

    // ------------------------------------------------------------------
    // Statistics counters (counted at input acceptance)
    // ------------------------------------------------------------------
`ifdef ONE_HOT_DECODE_STATS_EN
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [IDX_W:0]   c_num_sel = (IDX_W + 1)'(N);

    logic [CNT_W-1:0] r_class_cnt [N];
    logic [CNT_W-1:0] r_err_cnt;

    // Saturating counters; a same-cycle clear wins over any increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_class_cnt[i] <= '0;
            end
            r_err_cnt <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < N; i++) begin
                r_class_cnt[i] <= '0;
            end
            r_err_cnt <= '0;
        end else if (w_acc) begin
            if (!w_dec_err) begin
                if (r_class_cnt[w_dec_idx] != c_cnt_max) begin
                    r_class_cnt[w_dec_idx] <= r_class_cnt[w_dec_idx] + CNT_W'(1);
                end
            end else if (r_err_cnt != c_cnt_max) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    // Out-of-range selectors read as zero rather than aliasing a class
    assign stat_cnt = ({1'b0, stat_sel} < c_num_sel) ? r_class_cnt[stat_sel] : '0;
    assign err_cnt  = r_err_cnt;
`else
    // Statistics removed: inputs are intentionally left without a load
    logic w_unused_stats;
    assign w_unused_stats = ^{stat_clr, stat_sel};

    assign stat_cnt = '0;
    assign err_cnt  = '0;
`endif

endmodule : one_hot_decode_stream

`default_nettype wire

// File: tb/tb_one_hot_decode_stream.sv
// ============================================================================
// Module  : tb_one_hot_decode_stream
// Brief   : Self-checking bench for one_hot_decode_stream: vector table,
//           hand sequences for stall/skid/reset corners, and a randomized
//           run against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_one_hot_decode_stream;

    localparam int N       = 10;
    localparam int IDX_W   = $clog2(N);
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ONE_HOT_DECODE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_onehot;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_err;
    logic             stat_clr;
    logic [IDX_W-1:0] stat_sel;
    logic [CNT_W-1:0] stat_cnt;
    logic [CNT_W-1:0] err_cnt;

    // Second instance with 2-bit counters for saturation
    logic             s_in_valid;
    logic             s_in_ready;
    logic [N-1:0]     s_onehot;
    logic             s_out_valid;
    logic [IDX_W-1:0] s_out_idx;
    logic             s_out_err;
    logic             s_stat_clr;
    logic [IDX_W-1:0] s_stat_sel;
    logic [1:0]       s_stat_cnt;
    logic [1:0]       s_err_cnt;
    logic             s_out_ready;

    always #5 clk = ~clk;

    one_hot_decode_stream #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_onehot (in_onehot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_err   (out_err),
        .stat_clr  (stat_clr),
        .stat_sel  (stat_sel),
        .stat_cnt  (stat_cnt),
        .err_cnt   (err_cnt)
    );

    one_hot_decode_stream #(.N(N), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_onehot (s_onehot),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_idx   (s_out_idx),
        .out_err   (s_out_err),
        .stat_clr  (s_stat_clr),
        .stat_sel  (s_stat_sel),
        .stat_cnt  (s_stat_cnt),
        .err_cnt   (s_err_cnt)
    );

    // ------------------------------------------------------------------
    // Reference model: FIFO of decoded results plus counter arrays
    // ------------------------------------------------------------------
    typedef struct {
        int idx;
        bit err;
    } exp_t;

    exp_t q[$];
    int   m_cls [16];
    int   m_err;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        logic [N-1:0] vec;
        int           idx;
        bit           err;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lowest set bit isolated arithmetically; its log2 is the index
    function automatic void ref_decode(input logic [N-1:0] v, output int idx, output bit err);
        logic [N-1:0] low;
        low = v & (~v + N'(1));
        idx = (v == '0) ? 0 : $clog2(low);
        err = ($countones(v) != 1);
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < 16; i++) m_cls[i] = 0;
        m_err = 0;
    endtask

    // One clock: model decides acceptance/drain from its own occupancy
    task automatic tick();
        bit   acc, drn, de;
        int   di;
        exp_t e;
        acc = in_valid && (q.size() < 2);
        drn = (q.size() > 0) && out_ready;
        ref_decode(in_onehot, di, de);
        @(posedge clk);
        #1;
        if (drn) void'(q.pop_front());
        if (acc) begin
            e.idx = di;
            e.err = de;
            q.push_back(e);
        end
        if (stat_clr) begin
            for (int i = 0; i < 16; i++) m_cls[i] = 0;
            m_err = 0;
        end else if (acc) begin
            if (!de) m_cls[di] = sat_inc(m_cls[di]);
            else     m_err     = sat_inc(m_err);
        end
    endtask

    task automatic check_all(input string tag);
        int exp_stat;
        chk({tag, ".out_valid"}, out_valid, q.size() > 0);
        chk({tag, ".in_ready"},  in_ready,  q.size() < 2);
        if (q.size() > 0) begin
            chk({tag, ".out_idx"}, out_idx, q[0].idx);
            chk({tag, ".out_err"}, out_err, q[0].err);
        end
        exp_stat = (int'(stat_sel) < N) ? m_cls[stat_sel] : 0;
        chk({tag, ".stat_cnt"}, stat_cnt, STATS_ON ? exp_stat : 0);
        chk({tag, ".err_cnt"},  err_cnt,  STATS_ON ? m_err : 0);
    endtask

    initial begin
        // Table: one-hot classes, then malformed patterns
        for (int i = 0; i < N; i++) begin
            tbl[i].vec = N'(1) << i;
            tbl[i].idx = i;
            tbl[i].err = 1'b0;
        end
        tbl[10] = '{10'b0000000000, 0, 1'b1};
        tbl[11] = '{10'b0001010000, 4, 1'b1};
        tbl[12] = '{10'b1111111111, 0, 1'b1};
        tbl[13] = '{10'b1100000000, 8, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_onehot = '0; out_ready = 1'b0;
        stat_clr = 1'b0; stat_sel = '0;
        s_in_valid = 1'b0; s_onehot = '0; s_out_ready = 1'b1;
        s_stat_clr = 1'b0; s_stat_sel = IDX_W'(1);
        model_clear();

        // Reset state
        #12;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready",  in_ready,  1);
        chk("rst.out_idx",   out_idx,   0);
        chk("rst.out_err",   out_err,   0);
        chk("rst.err_cnt",   err_cnt,   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single vector, class 3
        in_valid = 1'b1; in_onehot = 10'b0000001000; out_ready = 1'b1;
        tick();
        chk("t1.out_idx",   out_idx,   3);
        chk("t1.out_err",   out_err,   0);
        chk("t1.out_valid", out_valid, 1);
        check_all("t1");

        // Table back-to-back with out_ready held high
        for (int i = 0; i < 14; i++) begin
            in_onehot = tbl[i].vec;
            tick();
            chk($sformatf("tbl%0d.out_idx", i),   out_idx,   tbl[i].idx);
            chk($sformatf("tbl%0d.out_err", i),   out_err,   tbl[i].err);
            chk($sformatf("tbl%0d.in_ready", i),  in_ready,  1);
            chk($sformatf("tbl%0d.out_valid", i), out_valid, 1);
            check_all($sformatf("tbl%0d", i));
        end
        in_valid = 1'b0;
        tick();
        check_all("drain");

        // Stall: 2 then 5 with out_ready low
        out_ready = 1'b0; in_valid = 1'b1; in_onehot = 10'b0000000100;
        tick();
        chk("stall.a.idx",   out_idx,  2);
        chk("stall.a.ready", in_ready, 1);
        in_onehot = 10'b0000100000;
        tick();
        chk("stall.b.idx",   out_idx,  2);
        chk("stall.b.ready", in_ready, 0);
        in_valid = 1'b0;
        tick();
        chk("stall.hold.idx", out_idx, 2);
        check_all("stall.hold");
        out_ready = 1'b1;
        #1;
        chk("stall.pre.idx", out_idx, 2);
        tick();
        chk("stall.c.idx",   out_idx,   5);
        chk("stall.c.ready", in_ready,  1);
        tick();
        chk("stall.d.valid", out_valid, 0);
        check_all("stall.d");

        // Statistics: 3x class 7, 1x malformed, then clear
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0; stat_sel = IDX_W'(7); in_valid = 1'b1;
        in_onehot = 10'b0010000000;
        repeat (3) tick();
        in_onehot = 10'b0000000011;
        tick();
        in_valid = 1'b0;
        tick();
        chk("stats.cls7", stat_cnt, STATS_ON ? 3 : 0);
        chk("stats.err",  err_cnt,  STATS_ON ? 1 : 0);
        stat_sel = IDX_W'(12);
        #1;
        chk("stats.sel_oob", stat_cnt, 0);
        stat_sel = IDX_W'(7);
        // Clear coinciding with an accept: clear wins
        stat_clr = 1'b1; in_valid = 1'b1;
        tick();
        stat_clr = 1'b0; in_valid = 1'b0;
        chk("stats.clr.cls7", stat_cnt, 0);
        chk("stats.clr.err",  err_cnt,  0);
        tick();
        check_all("stats.after");

        // Saturation on the 2-bit instance: 5x class 1
        s_in_valid = 1'b1; s_onehot = 10'b0000000010;
        repeat (3) @(posedge clk);
        #1;
        chk("sat.3", s_stat_cnt, STATS_ON ? 3 : 0);
        repeat (2) @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        chk("sat.5",       s_stat_cnt, STATS_ON ? 3 : 0);
        chk("sat.out_idx", s_out_idx,  1);
        chk("sat.ready",   s_in_ready, 1);

        // Reset while both registers are full
        stat_clr = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        in_onehot = 10'b0000000001;
        tick();
        in_onehot = 10'b1000000000;
        tick();
        chk("midrst.pre.ready", in_ready, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.in_ready",  in_ready,  1);
        chk("midrst.stat_cnt",  stat_cnt,  0);
        chk("midrst.err_cnt",   err_cnt,   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1; in_valid = 1'b1; in_onehot = 10'b0001000000;
        tick();
        chk("midrst.next.idx", out_idx, 6);
        chk("midrst.next.err", out_err, 0);
        check_all("midrst.next");

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) != 0) in_onehot = N'(1) << $urandom_range(0, N - 1);
            else                           in_onehot = N'($urandom);
            stat_sel  = IDX_W'($urandom_range(0, 15));
            stat_clr  = ($urandom_range(0, 31) == 0);
            tick();
            check_all($sformatf("rnd%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_one_hot_decode_stream

`default_nettype wire
